// File: rtl/cw_deserializer.sv
// Serial-to-parallel front end for the (25,16) burst-4 decoder: frames bits into codewords
// and hands them over a valid/ready register. Optional error injection: CW_DESER_ERR_INJECT_EN.
//
//   state | meaning
//   SYNC  | waiting for a valid bit flagged sof
//   RUN   | collecting bits 1..N-1 of the current frame
module cw_deserializer #(
  parameter int N      = 25,
  parameter int CNT_W  = 5,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin_valid,
  input  logic              sin_data,
  input  logic              sin_sof,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic [0:N-1]      cw_data,
  output logic              overflow,
  output logic              frame_err,
  output logic [DROP_W-1:0] drop_cnt
`ifdef CW_DESER_ERR_INJECT_EN
  ,
  input  logic              inj_en,
  input  logic [CNT_W-1:0]  inj_pos,
  input  logic [3:0]        inj_pat
`endif
);

  typedef enum logic {SYNC, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [0:N-1]     sr;
  logic [0:N-1]     word;
  logic [0:N-1]     inj_mask;
  logic             last_bit;
  logic             can_load;

  assign last_bit = (state == RUN) && sin_valid && !sin_sof && (cnt == CNT_W'(N-1));
  assign can_load = !cw_valid || cw_ready;

  always_comb begin
    word        = sr;
    word[N-1]   = sin_data;
    inj_mask    = '0;
`ifdef CW_DESER_ERR_INJECT_EN
    // Pattern sits at index 0 and shifts toward N-1; anything past N-1 falls off.
    if (inj_en)
      inj_mask = {inj_pat, {(N-4){1'b0}}} >> inj_pos;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      cnt       <= '0;
      sr        <= '0;
      cw_valid  <= 1'b0;
      cw_data   <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      if (cw_ready)
        cw_valid <= 1'b0;

      if (sin_valid) begin
        case (state)
          SYNC: begin
            if (sin_sof) begin
              sr    <= {sin_data, {(N-1){1'b0}}};
              cnt   <= CNT_W'(1);
              state <= RUN;
            end
          end
          RUN: begin
            if (sin_sof) begin
              // A sof mid-frame (including on bit N-1) restarts rather than completes.
              frame_err <= 1'b1;
              sr        <= {sin_data, {(N-1){1'b0}}};
              cnt       <= CNT_W'(1);
            end else if (last_bit) begin
              cnt   <= '0;
              state <= SYNC;
              if (can_load) begin
                cw_data  <= word ^ inj_mask;
                cw_valid <= 1'b1;
              end else begin
                overflow <= 1'b1;
                if (drop_cnt != {DROP_W{1'b1}})
                  drop_cnt <= drop_cnt + 1'b1;
              end
            end else begin
              sr[cnt] <= sin_data;
              cnt     <= cnt + 1'b1;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cw_deserializer.sv
// Directed bench for cw_deserializer: vector table for basic framing plus hand-written
// sequences for backpressure, resync, reset and saturation corners.
module tb_cw_deserializer;
  localparam int N = 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sin_data = 1'b0;
  logic         sin_sof = 1'b0;
  logic         cw_ready = 1'b0;
  logic         cw_valid;
  logic [0:N-1] cw_data;
  logic         overflow;
  logic         frame_err;
  logic [7:0]   drop_cnt;
  logic         inj_en = 1'b0;
  logic [4:0]   inj_pos = '0;
  logic [3:0]   inj_pat = '0;

  cw_deserializer #(.N(N), .CNT_W(5), .DROP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin_valid (sin_valid),
    .sin_data  (sin_data),
    .sin_sof   (sin_sof),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .overflow  (overflow),
    .frame_err (frame_err),
    .drop_cnt  (drop_cnt)
`ifdef CW_DESER_ERR_INJECT_EN
    ,
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
    .inj_pat   (inj_pat)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int xfer_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;

  always @(posedge clk) begin
    if (cw_valid && cw_ready) xfer_cnt++;
    if (frame_err) ferr_cnt++;
    if (overflow) ovf_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic d, input logic s);
    sin_valid = 1'b1;
    sin_data  = d;
    sin_sof   = s;
    @(posedge clk); #1;
    sin_valid = 1'b0;
    sin_data  = 1'b0;
    sin_sof   = 1'b0;
  endtask

  // Invalid cycles carry noisy data/sof that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      sin_valid = 1'b0;
      sin_data  = 1'b1;
      sin_sof   = 1'b1;
      @(posedge clk); #1;
    end
    sin_data = 1'b0;
    sin_sof  = 1'b0;
  endtask

  task automatic send_bits(input logic [0:N-1] f, input int from, input int to,
                           input bit sof_first, input bit gaps);
    for (int i = from; i <= to; i++) begin
      if (gaps && (i % 3 == 1)) idle(1);
      send_bit(f[i], sof_first && (i == from));
    end
  endtask

  typedef struct {
    logic [0:N-1] frame;
    bit           junk;
    bit           gaps;
    logic [0:N-1] exp;
  } vec_t;

  vec_t vecs[5];
  int   x0, o0, f0;

  initial begin
    vecs[0] = '{25'h1FFFFFF, 1'b0, 1'b0, 25'h1FFFFFF};
    vecs[1] = '{25'h1555555, 1'b0, 1'b0, 25'h1555555};
    vecs[2] = '{25'h0000001, 1'b1, 1'b1, 25'h0000001};
    vecs[3] = '{25'h1000000, 1'b0, 1'b1, 25'h1000000};
    vecs[4] = '{25'h0ABCDEF, 1'b1, 1'b0, 25'h0ABCDEF};

    #22;
    chk("rst_valid", cw_valid, 0);
    chk("rst_data", cw_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: one frame each, decoder always ready.
    cw_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].junk) send_bits(vecs[v].frame, 0, 2, 1'b0, 1'b0);
      send_bits(vecs[v].frame, 0, N-1, 1'b1, vecs[v].gaps);
      chk($sformatf("vec%0d_valid", v), cw_valid, 1);
      chk($sformatf("vec%0d_data", v), cw_data, vecs[v].exp);
      chk($sformatf("vec%0d_ovf", v), overflow, 0);
      chk($sformatf("vec%0d_drop", v), drop_cnt, 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_clear", v), cw_valid, 0);
    end

    // Backpressure: second frame dropped, first held, one transfer on release.
    cw_ready = 1'b0;
    x0 = xfer_cnt;
    o0 = ovf_cnt;
    send_bits(25'h1FFFFFF, 0, N-1, 1'b1, 1'b0);
    chk("bp_a_valid", cw_valid, 1);
    send_bits(25'h0000000, 0, N-1, 1'b1, 1'b0);
    chk("bp_ovf", overflow, 1);
    chk("bp_drop", drop_cnt, 1);
    chk("bp_hold_data", cw_data, 25'h1FFFFFF);
    chk("bp_hold_valid", cw_valid, 1);
    idle(1);
    chk("bp_ovf_pulse", overflow, 0);
    cw_ready = 1'b1;
    @(posedge clk); #1;
    cw_ready = 1'b0;
    chk("bp_released", cw_valid, 0);
    idle(3);
    chk("bp_xfers", xfer_cnt - x0, 1);
    chk("bp_ovf_count", ovf_cnt - o0, 1);

    // Completion and consume in the same cycle: replace, no drop.
    send_bits(25'h1FFFFFF, 0, N-1, 1'b1, 1'b0);
    send_bits(25'h0F0F0F3, 0, N-2, 1'b1, 1'b0);
    cw_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("sim_valid", cw_valid, 1);
    chk("sim_data", cw_data, 25'h0F0F0F3);
    chk("sim_ovf", overflow, 0);
    chk("sim_drop", drop_cnt, 1);
    @(posedge clk); #1;
    chk("sim_clear", cw_valid, 0);

    // Resync: sof again at the 11th bit.
    f0 = ferr_cnt;
    send_bits(25'h1234567, 0, 9, 1'b1, 1'b0);
    chk("rs_no_valid", cw_valid, 0);
    send_bit(1'b1, 1'b1);
    chk("rs_ferr", frame_err, 1);
    send_bits(25'h1ABCDE5, 1, N-1, 1'b0, 1'b0);
    chk("rs_ferr_pulse", frame_err, 0);
    chk("rs_valid", cw_valid, 1);
    chk("rs_data", cw_data, 25'h1ABCDE5);
    chk("rs_ferr_count", ferr_cnt - f0, 1);
    @(posedge clk); #1;

    // sof landing on bit N-1 restarts instead of completing.
    send_bits(25'h155AA33, 0, N-2, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("last_sof_ferr", frame_err, 1);
    chk("last_sof_no_valid", cw_valid, 0);
    send_bits(25'h1C3A5F1, 1, N-1, 1'b0, 1'b0);
    chk("last_sof_valid", cw_valid, 1);
    chk("last_sof_data", cw_data, 25'h1C3A5F1);
    @(posedge clk); #1;

    // Async reset mid-frame with a word held in the output register.
    cw_ready = 1'b0;
    send_bits(25'h1FFFFFF, 0, N-1, 1'b1, 1'b0);
    send_bits(25'h0DEAD01, 0, 11, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", cw_valid, 0);
    chk("ar_data", cw_data, 0);
    chk("ar_drop", drop_cnt, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_bits(25'h0DEAD01, 12, N-1, 1'b0, 1'b0);
    chk("ar_tail_ignored", cw_valid, 0);
    cw_ready = 1'b1;
    send_bits(25'h0DEAD01, 0, N-1, 1'b1, 1'b0);
    chk("ar_new_valid", cw_valid, 1);
    chk("ar_new_data", cw_data, 25'h0DEAD01);
    chk("ar_ovf", overflow, 0);
    chk("ar_ferr", frame_err, 0);
    chk("ar_new_drop", drop_cnt, 0);
    @(posedge clk); #1;

`ifdef CW_DESER_ERR_INJECT_EN
    inj_en = 1'b1; inj_pos = 5'd21; inj_pat = 4'b1010;
    send_bits(25'h1FFFFFF, 0, N-1, 1'b1, 1'b0);
    chk("inj_21", cw_data, 25'h1FFFFF5);
    inj_pos = 5'd23; inj_pat = 4'b1111;
    send_bits(25'h1FFFFFF, 0, N-1, 1'b1, 1'b0);
    chk("inj_23", cw_data, 25'h1FFFFFC);
    inj_pos = 5'd30;
    send_bits(25'h1FFFFFF, 0, N-1, 1'b1, 1'b0);
    chk("inj_out_of_range", cw_data, 25'h1FFFFFF);
    inj_en = 1'b0; inj_pos = 5'd0;
    send_bits(25'h1FFFFFF, 0, N-1, 1'b1, 1'b0);
    chk("inj_off", cw_data, 25'h1FFFFFF);
    @(posedge clk); #1;
`endif

    // Drop counter saturation.
    cw_ready = 1'b0;
    repeat (260) send_bits(25'h0000000, 0, N-1, 1'b1, 1'b0);
    chk("sat_ovf", overflow, 1);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_valid", cw_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
